// File: rtl/lsu_mem_master.sv
// Load/store initiator for the memory data port. One request in flight at a time.
// Sub-word stores use read-modify-write. Writes are held SETUP/PULSE/HOLD so the delayed byte commits stay safe.
module lsu_mem_master #(
  parameter logic [31:0] DATA_LIMIT = 32'h0000_0FFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, READ, SETUP, PULSE, HOLD, RESP} state_t;

  state_t      state, state_n;
  logic        accept, req_err;
  logic        we_q, uns_q;
  logic [1:0]  size_q, lane_q;
  logic [15:0] wlo_q;

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   load_ext = {{24{~uns & b[7]}}, b};
      2'b01:   load_ext = {{16{~uns & h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                              input logic [1:0] lane, input logic [1:0] size);
    store_merge = w;
    if (size == 2'b00) store_merge[{lane, 3'b000} +: 8]     = d[7:0];
    else               store_merge[{lane[1], 4'b0000} +: 16] = d;
  endfunction

  assign req_ready = rst_n & (state == IDLE);
  assign accept    = req_valid & req_ready;

  always_comb begin
    req_err = (req_size == 2'b11)
            | ((req_size == 2'b01) & req_addr[0])
            | ((req_size == 2'b10) & (|req_addr[1:0]))
            | ((req_addr & ~32'd3) > DATA_LIMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Word stores skip READ; everything else that touches memory reads first.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) begin
        if (req_err)                          state_n = RESP;
        else if (req_we && req_size == 2'b10) state_n = SETUP;
        else                                  state_n = READ;
      end
      READ:    state_n = we_q ? SETUP : RESP;
      SETUP:   state_n = PULSE;
      PULSE:   state_n = HOLD;
      HOLD:    state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b00;
      lane_q <= 2'b00;
      wlo_q  <= '0;
    end else if (accept) begin
      we_q   <= req_we;
      uns_q  <= req_unsigned;
      size_q <= req_size;
      lane_q <= req_addr[1:0];
      wlo_q  <= req_wdata[15:0];
    end
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      mem_read   <= (state_n == READ);
      mem_write  <= (state_n == PULSE);
      resp_valid <= (state_n == RESP);
      resp_err   <= accept & req_err;
      resp_rdata <= '0;
      if (accept && !req_err) mem_addr <= {req_addr[31:2], 2'b00};
      if (accept && req_we && req_size == 2'b10) mem_wdata <= req_wdata;
      if (state == READ) begin
        if (we_q) mem_wdata  <= store_merge(mem_rdata, wlo_q, lane_q, size_q);
        else      resp_rdata <= load_ext(mem_rdata, lane_q, size_q, uns_q);
      end
    end
  end

endmodule
